// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch/decode decoupling queue.
//   FQ_DEPTH_DEFAULT : default number of queue entries
//   FQ_AW / FQ_IW    : PC and instruction widths of one queue entry
//   NOP_INSTR        : all-zero instruction, shown to decode when nothing is queued
//   fetch_entry_t    : one stored {pc, instr} pair
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int FQ_DEPTH_DEFAULT = 4;
   localparam int FQ_AW            = 32;
   localparam int FQ_IW            = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [FQ_AW-1:0] pc;
      logic [FQ_IW-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// ---------------------------------------------------------------------------
// fetch_queue_mem
// DEPTH x fetch_entry_t register array backing the fetch queue.
// Ports:
//   Clk     : clock, write on rising edge
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : entry to store
//   rd_addr : asynchronous read index (queue head)
//   rd_data : entry at rd_addr
// The array has no reset: flushing only moves the pointers, so stale
// contents are never visible to decode.
// ---------------------------------------------------------------------------
module fetch_queue_mem
   import fetch_pkg::*;
#(
   parameter  int DEPTH = FQ_DEPTH_DEFAULT,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          wr_en,
   input  logic [PW-1:0] wr_addr,
   input  fetch_entry_t  wr_data,
   input  logic [PW-1:0] rd_addr,
   output fetch_entry_t  rd_data
);

   fetch_entry_t mem_r [DEPTH];

   // Single synchronous write port.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Circular FIFO of {PC, instruction} pairs between the fetch and decode
// stages. in_ready drives the upstream PC write enable, so a full queue
// freezes the PC; Flush drops every wrong-path entry on a taken branch/jump.
//
// Ports:
//   Clk, Reset (synchronous, active-high), Flush (synchronous discard)
//   in_valid / in_pc / in_instr / in_ready    : fetch side
//   out_valid / out_pc / out_instr / out_ready : decode side
//   count                                      : occupancy 0..DEPTH
//
// Build option: define FETCH_QUEUE_BYPASS_EN for a zero-latency
// pass-through when the queue is empty and decode is ready. Without it
// there is no combinational in->out path (1-cycle minimum latency).
//
// AW/IW must match the entry layout in fetch_pkg.
// ---------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = FQ_DEPTH_DEFAULT,
   parameter  int AW    = FQ_AW,
   parameter  int IW    = FQ_IW,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Flush,
   input  logic          in_valid,
   input  logic [AW-1:0] in_pc,
   input  logic [IW-1:0] in_instr,
   output logic          in_ready,
   output logic          out_valid,
   output logic [AW-1:0] out_pc,
   output logic [IW-1:0] out_instr,
   input  logic          out_ready,
   output logic [CW-1:0] count
);

   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   logic          queue_valid_s;
   logic          bypass_s;
   logic          push_s;
   logic          pop_s;
   fetch_entry_t  wr_entry_s;
   fetch_entry_t  rd_entry_s;

   assign queue_valid_s = (count_r != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue and decode ready: hand the pair straight through, store nothing.
   assign bypass_s = (count_r == '0) && in_valid && out_ready && !Flush && !Reset;
`else
   assign bypass_s = 1'b0;
`endif

   // Full blocks pushes even if a pop happens this cycle; ready rises next cycle.
   assign in_ready = !Reset && (count_r != CW'(DEPTH));

   assign push_s = in_valid && in_ready && !Flush && !bypass_s;
   assign pop_s  = queue_valid_s && out_ready && !Flush;

   assign wr_entry_s.pc    = in_pc;
   assign wr_entry_s.instr = in_instr;

   fetch_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .Clk     (Clk),
      .wr_en   (push_s),
      .wr_addr (wr_ptr_r),
      .wr_data (wr_entry_s),
      .rd_addr (rd_ptr_r),
      .rd_data (rd_entry_s)
   );

   // Pointer and occupancy update; Reset and Flush both empty the queue.
   always_ff @(posedge Clk) begin
      if (Reset || Flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Decode-side mux: bypass pair, queue head, or NOP when nothing is available.
   always_comb begin
      out_valid = 1'b0;
      out_pc    = '0;
      out_instr = IW'(NOP_INSTR);
      if (bypass_s) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_instr = in_instr;
      end else if (queue_valid_s) begin
         out_valid = 1'b1;
         out_pc    = rd_entry_s.pc;
         out_instr = rd_entry_s.instr;
      end else begin
         out_valid = 1'b0;
         out_pc    = '0;
         out_instr = IW'(NOP_INSTR);
      end
   end

   assign count = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. Stimulus keeps a small occupancy model and
// pushes the expected {pc, instr} of every accepted pair into a scoreboard;
// a negedge monitor compares the head whenever the DUT shows out_valid and
// retires it on a handshake. Honours FETCH_QUEUE_BYPASS_EN when defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Flush;
   logic          in_valid;
   logic [31:0]   in_pc;
   logic [31:0]   in_instr;
   logic          in_ready;
   logic          out_valid;
   logic [31:0]   out_pc;
   logic [31:0]   out_instr;
   logic          out_ready;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;
   int model_count = 0;
   bit mon_en = 1'b0;
   logic [63:0] exp_q [$];

   fetch_queue #(.DEPTH(DEPTH), .AW(32), .IW(32)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Flush     (Flush),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard monitor: compare head while valid, retire on handshake.
   always @(negedge Clk) begin
      if (mon_en && out_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL head: got pc %h instr %h expected no valid output", out_pc, out_instr);
         end else begin
            if ({out_pc, out_instr} !== exp_q[0]) begin
               n_fail++;
               $display("FAIL head: got %h expected %h at %0t", {out_pc, out_instr}, exp_q[0], $time);
            end
            if (out_ready && !Flush && !Reset) begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // One clock: apply inputs, check handshake/occupancy at negedge, update model at posedge.
   task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
      logic byp, m_push, m_pop;
      in_valid  = v;
      in_pc     = pc;
      in_instr  = ins_of(pc);
      out_ready = ordy;
      Flush     = fl;
      byp    = BYP && (model_count == 0) && v && ordy && !fl && !Reset;
      if (byp) exp_q.push_back({pc, ins_of(pc)});
      m_push = v && !Reset && (model_count != DEPTH) && !fl && !byp;
      m_pop  = (model_count != 0) && ordy && !fl;
      @(negedge Clk);
      check("in_ready", 64'(in_ready), 64'(!Reset && (model_count != DEPTH)));
      check("out_valid", 64'(out_valid), 64'((model_count != 0) || byp));
      check("count", 64'(count), 64'(model_count));
      if (model_count == 0 && !byp) begin
         check("empty_out", {out_pc, out_instr}, 64'h0);
      end
      @(posedge Clk);
      if (Reset || fl) begin
         model_count = 0;
         exp_q.delete();
      end else begin
         model_count = model_count + int'(m_push) - int'(m_pop);
         if (m_push) exp_q.push_back({pc, ins_of(pc)});
      end
      #1;
   endtask

   initial begin
      Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; in_pc = 32'h0;
      in_instr = 32'h0; out_ready = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset  = 1'b0;
      mon_en = 1'b1;
      step(1'b0, 32'h0, 1'b0, 1'b0);                 // post-reset state

      // Three pushes while decode stalls, then drain.
      step(1'b1, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h4, 1'b0, 1'b0);
      step(1'b1, 32'h8, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);                 // count 3, head 0x0
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Fill, ignored fifth pair, pop while full, ready returns next cycle.
      step(1'b1, 32'h20, 1'b0, 1'b0);
      step(1'b1, 32'h24, 1'b0, 1'b0);
      step(1'b1, 32'h28, 1'b0, 1'b0);
      step(1'b1, 32'h2C, 1'b0, 1'b0);
      step(1'b1, 32'h10, 1'b0, 1'b0);                // full: ignored
      step(1'b1, 32'h10, 1'b1, 1'b0);                // pop only
      step(1'b0, 32'h0, 1'b0, 1'b0);                 // in_ready back, count 3
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Streaming: 16 pairs, pointers wrap four times, count stays 1.
      for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Flush with same-cycle push, then refill.
      step(1'b1, 32'h80, 1'b0, 1'b0);
      step(1'b1, 32'h84, 1'b0, 1'b0);
      step(1'b1, 32'h88, 1'b0, 1'b0);
      step(1'b1, 32'h100, 1'b0, 1'b1);
      step(1'b1, 32'h200, 1'b0, 1'b0);               // count 0, out_valid 0 here
      step(1'b0, 32'h0, 1'b1, 1'b0);                 // head 0x200
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Reset mid-operation with in_valid high.
      step(1'b1, 32'h300, 1'b0, 1'b0);
      step(1'b1, 32'h304, 1'b0, 1'b0);
      Reset = 1'b1;
      step(1'b1, 32'h308, 1'b0, 1'b0);
      Reset = 1'b0;
      step(1'b0, 32'h0, 1'b0, 1'b0);

      // Empty queue, decode ready: bypass when built in, else 1-cycle latency.
      step(1'b1, 32'h40, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
